sobel_window: RTL
=================

# sobel_window

Streaming 3x3 neighbourhood generator that feeds the combinational Sobel operator. Consumes a raster-order 8-bit grayscale stream from a first-word-fall-through input FIFO, buffers two image lines, and emits one registered 8-neighbour window per pixel, in raster order, through a valid/ready output stage. It sits between the grayscale FIFO and the Sobel operator in the edge-detect pipeline. Image borders are flagged and padded.

## Interface
- `WIDTH`, 720: pixels per line; must be ≥ 3.
- `HEIGHT`, 540: lines per frame; must be ≥ 3.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_dout` in 8: pixel at the head of the input FIFO.
- `in_empty` in 1: input FIFO empty.
- `in_rd_en` out 1: pop input FIFO; combinational.
- `out_top_L`, `out_top_C`, `out_top_R`, `out_mid_L`, `out_mid_R`, `out_bot_L`, `out_bot_C`, `out_bot_R` out 8 each: neighbours of the current centre pixel.
- `out_border` out 1: centre lies on row 0, row HEIGHT-1, col 0 or col WIDTH-1.
- `out_last` out 1: window for centre (HEIGHT-1, WIDTH-1).
- `out_valid` out 1: window valid.
- `out_ready` in 1: downstream accepts the window.

## Operation
- `advance = !out_valid || out_ready`. A step is one window-register shift.
- In FILL and RUN, a step occurs when `advance && !in_empty`. In that cycle, `in_rd_en` is 1.
- In FLUSH, a step occurs on `advance` with `in_dout` replaced by 0, and `in_rd_en` is 0.
- Step index k counts from 0 per frame.
  - Line buffers: lb_old[col] ← lb_new[col], lb_new[col] ← pixel.
  - The 3x3 register shifts left. The new right column is {lb_old[col], lb_new[col], pixel}.
  - Here col = k mod WIDTH.
- Step k ≥ WIDTH+1 completes the window for centre index c = k-WIDTH-1, at row c/WIDTH, col c mod WIDTH. Column wrap needs no special case, because wrapped neighbours are always border-masked.
- States:
  - FILL (k < WIDTH+1, no emit) → RUN at k = WIDTH+1.
  - RUN (emit each step) → FLUSH after the step that consumes pixel HEIGHT·WIDTH-1.
  - FLUSH runs WIDTH+1 steps, emitting each. It returns to FILL after the step with `out_last`, and k, the row counter and the column counter clear.
- Border masking: any neighbour outside the image outputs 0. `out_border` is set for every edge centre.
- Arithmetic: pixels are unsigned 8-bit and pass through unmodified. Counters are sized with `$clog2` of WIDTH·HEIGHT+WIDTH+1.
- Line-buffer contents need not be cleared between frames. Masking covers every stale read.

## Timing
- Reset values:
  - `out_valid` = 0, `out_border` = 0, `out_last` = 0, all neighbour outputs 0.
  - State = FILL, k = 0.
  - `in_rd_en` = 0 while `reset` is high.
- Latency: the window for centre (r,c) is presented on the cycle after the step that pops pixel r·WIDTH+c+WIDTH+1 (or the equivalent FLUSH step).
- Outputs hold stable while `out_valid && !out_ready`. No pop occurs during such a stall.
- Throughput is one window per cycle when `out_ready` = 1 and the input is never empty.
- Simultaneous accept-and-step: the output register reloads in the same cycle; there is no bubble.
- Input empty in RUN: `out_valid` drops after the pending window is accepted. No state change occurs.
- Reset mid-frame returns to FILL immediately. The partial frame is discarded and no window is emitted for it.

## Configuration
- `SOBEL_WINDOW_REPLICATE_EN` defined:
  - Out-of-image neighbours take the clamped in-image pixel (edge replication). For example, `out_top_C` at row 0 equals the centre pixel.
  - `out_border` is still asserted.
  - The centre register is used internally only.
- `SOBEL_WINDOW_REPLICATE_EN` undefined: out-of-image neighbours are 0.

## Structure
- `sobel_pkg` holds:
  - the `pixel_t` type (logic [7:0]);
  - a `window_t` struct of the eight neighbours plus border and last flags;
  - the state enum {FILL, RUN, FLUSH};
  - default WIDTH and HEIGHT constants.
- Sub-module `sobel_line_buffer`: a WIDTH-deep × 8 array with read-before-write at one address per step. It is instantiated twice (lb_old and lb_new).

## Test plan
- WIDTH=4, HEIGHT=3, ramp pixels 0..11, `out_ready`=1:
  - exactly 12 windows are emitted;
  - centre (1,1) gives top {0,1,2}, mid L/R {4,6}, bot {8,9,10}, with `out_border`=0;
  - `out_last` is set only on window 12.
- Same frame: window for centre (0,0) has `out_top_*`=0, `out_mid_L`=0, `out_bot_L`=0, `out_mid_R`=1, `out_bot_C`=4, `out_bot_R`=5, `out_border`=1. With `SOBEL_WINDOW_REPLICATE_EN`: top {0,0,1}, `out_mid_L`=0, `out_bot_L`=4.
- Hold `out_ready`=0 for 5 cycles mid-RUN: outputs stay constant, `in_rd_en`=0 throughout, and no window is lost or duplicated.
- Starve the input for 3 cycles after pixel 6: `out_valid` falls, then the stream resumes with correct values. The first window appears exactly 1 cycle after pixel 5 is popped.
- Two back-to-back frames (ramp, then constant 0x80): the second frame's windows contain no first-frame values, including at the borders.
- Assert `reset` for 1 cycle after pixel 7: all outputs are 0 the next cycle, and a full new frame then produces 12 correct windows.

Source files
------------

// File: rtl/sobel_window_pkg.sv
// sobel_pkg: shared pixel, window and state types for the Sobel neighbourhood generator.
// Imported by the interface, the line buffer and the sobel_window top.
package sobel_pkg;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        pixel_t top_l;
        pixel_t top_c;
        pixel_t top_r;
        pixel_t mid_l;
        pixel_t mid_r;
        pixel_t bot_l;
        pixel_t bot_c;
        pixel_t bot_r;
        logic   border;
        logic   last;
    } window_t;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    localparam int DEFAULT_WIDTH  = 720;
    localparam int DEFAULT_HEIGHT = 540;

    function automatic pixel_t gate_pixel(input pixel_t p, input logic keep);
        return keep ? p : '0;
    endfunction

endpackage

// File: rtl/sobel_window_if.sv
// sobel_window_if: FWFT input FIFO side plus the valid/ready window output of sobel_window.
// master is the window generator, slave is the FIFO/consumer environment around it.
interface sobel_window_if;
    import sobel_pkg::*;

    pixel_t in_dout;
    logic   in_empty;
    logic   in_rd_en;

    pixel_t out_top_L;
    pixel_t out_top_C;
    pixel_t out_top_R;
    pixel_t out_mid_L;
    pixel_t out_mid_R;
    pixel_t out_bot_L;
    pixel_t out_bot_C;
    pixel_t out_bot_R;
    logic   out_border;
    logic   out_last;
    logic   out_valid;
    logic   out_ready;

    modport master (
        input  in_dout, in_empty, out_ready,
        output in_rd_en,
        output out_top_L, out_top_C, out_top_R, out_mid_L, out_mid_R,
        output out_bot_L, out_bot_C, out_bot_R, out_border, out_last, out_valid
    );

    modport slave (
        output in_dout, in_empty, out_ready,
        input  in_rd_en,
        input  out_top_L, out_top_C, out_top_R, out_mid_L, out_mid_R,
        input  out_bot_L, out_bot_C, out_bot_R, out_border, out_last, out_valid
    );

endinterface

// File: rtl/sobel_window_line_buffer.sv
// sobel_line_buffer: one image line of pixels, read-before-write at a single address per step.
// Contents are never cleared; the window masking hides anything stale.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_WIDTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pixel_t                   wr_data,
    output pixel_t                   rd_data
);

    pixel_t mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window.sv
// sobel_window: buffers two image lines and emits one registered 3x3 neighbourhood per pixel.
// Define SOBEL_WINDOW_REPLICATE_EN to replicate edge pixels instead of zero-padding outside the image.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic           clock,
    input  logic           reset,
    sobel_window_if.master bus
);

    localparam int CNT_W  = $clog2(WIDTH * HEIGHT + WIDTH + 1);
    localparam int ADDR_W = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);

    localparam logic [CNT_W-1:0]  K_FILL_END = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  K_LAST_PIX = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0]  K_END      = CNT_W'(WIDTH * HEIGHT + WIDTH);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);

    state_t state, state_next;

    logic [CNT_W-1:0]  k;
    logic [ADDR_W-1:0] lb_col;
    logic [ADDR_W-1:0] c_col;
    logic [ROW_W-1:0]  c_row;

    logic   advance, step, emit, rd_en, lb_we;
    pixel_t pixel, lb_top, lb_mid;

    // Two stored columns are enough: the third (newest) column is formed from the line buffers each step.
    pixel_t  win [0:2][0:1];
    pixel_t  g   [0:2][0:2];
    window_t win_next, out_q;
    logic    out_valid_q;
    logic    row_first, row_last, col_first, col_last;

    assign advance = !out_valid_q || bus.out_ready;
    assign lb_we   = step && !reset;

    sobel_line_buffer #(.DEPTH(WIDTH)) lb_new_i (
        .clock   (clock),
        .wr_en   (lb_we),
        .addr    (lb_col),
        .wr_data (pixel),
        .rd_data (lb_mid)
    );

    sobel_line_buffer #(.DEPTH(WIDTH)) lb_old_i (
        .clock   (clock),
        .wr_en   (lb_we),
        .addr    (lb_col),
        .wr_data (lb_mid),
        .rd_data (lb_top)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (step && k == K_FILL_END) state_next = RUN;
            RUN:     if (step && k == K_LAST_PIX) state_next = FLUSH;
            FLUSH:   if (step && k == K_END)      state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // FLUSH drains the pipeline with zero pixels and never touches the FIFO.
    always_comb begin
        step  = 1'b0;
        emit  = 1'b0;
        rd_en = 1'b0;
        pixel = bus.in_dout;
        case (state)
            FILL: begin
                step  = advance && !bus.in_empty;
                rd_en = step && !reset;
            end
            RUN: begin
                step  = advance && !bus.in_empty;
                emit  = step;
                rd_en = step && !reset;
            end
            FLUSH: begin
                step  = advance;
                emit  = step;
                pixel = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k      <= '0;
            lb_col <= '0;
            c_col  <= '0;
            c_row  <= '0;
        end else if (step) begin
            if (state == FLUSH && k == K_END) begin
                k      <= '0;
                lb_col <= '0;
                c_col  <= '0;
                c_row  <= '0;
            end else begin
                k      <= k + 1'b1;
                lb_col <= (lb_col == COL_LAST) ? '0 : lb_col + 1'b1;
                if (emit) begin
                    if (c_col == COL_LAST) begin
                        c_col <= '0;
                        c_row <= c_row + 1'b1;
                    end else begin
                        c_col <= c_col + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win <= '{default: '0};
        end else if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= g[r][2];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            g[r][0] = win[r][0];
            g[r][1] = win[r][1];
        end
        g[0][2] = lb_top;
        g[1][2] = lb_mid;
        g[2][2] = pixel;
    end

    assign row_first = (c_row == '0);
    assign row_last  = (c_row == ROW_LAST);
    assign col_first = (c_col == '0);
    assign col_last  = (c_col == COL_LAST);

`ifdef SOBEL_WINDOW_REPLICATE_EN
    logic [1:0] rt, rb, cl, cr;

    assign rt = row_first ? 2'd1 : 2'd0;
    assign rb = row_last  ? 2'd1 : 2'd2;
    assign cl = col_first ? 2'd1 : 2'd0;
    assign cr = col_last  ? 2'd1 : 2'd2;

    always_comb begin
        win_next.top_l  = g[rt][cl];
        win_next.top_c  = g[rt][1];
        win_next.top_r  = g[rt][cr];
        win_next.mid_l  = g[1][cl];
        win_next.mid_r  = g[1][cr];
        win_next.bot_l  = g[rb][cl];
        win_next.bot_c  = g[rb][1];
        win_next.bot_r  = g[rb][cr];
        win_next.border = row_first || row_last || col_first || col_last;
        win_next.last   = row_last && col_last;
    end
`else
    // Wrapped columns and unwritten buffer rows only ever land on masked positions.
    always_comb begin
        win_next.top_l  = gate_pixel(g[0][0], !row_first && !col_first);
        win_next.top_c  = gate_pixel(g[0][1], !row_first);
        win_next.top_r  = gate_pixel(g[0][2], !row_first && !col_last);
        win_next.mid_l  = gate_pixel(g[1][0], !col_first);
        win_next.mid_r  = gate_pixel(g[1][2], !col_last);
        win_next.bot_l  = gate_pixel(g[2][0], !row_last && !col_first);
        win_next.bot_c  = gate_pixel(g[2][1], !row_last);
        win_next.bot_r  = gate_pixel(g[2][2], !row_last && !col_last);
        win_next.border = row_first || row_last || col_first || col_last;
        win_next.last   = row_last && col_last;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (emit) begin
            out_q       <= win_next;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_rd_en   = rd_en;
    assign bus.out_top_L  = out_q.top_l;
    assign bus.out_top_C  = out_q.top_c;
    assign bus.out_top_R  = out_q.top_r;
    assign bus.out_mid_L  = out_q.mid_l;
    assign bus.out_mid_R  = out_q.mid_r;
    assign bus.out_bot_L  = out_q.bot_l;
    assign bus.out_bot_C  = out_q.bot_c;
    assign bus.out_bot_R  = out_q.bot_r;
    assign bus.out_border = out_q.border;
    assign bus.out_last   = out_q.last;
    assign bus.out_valid  = out_valid_q;

endmodule
